regfile_op_sequencer: RTL and testbench
=======================================

Name: regfile_op_sequencer

Overview:
- Command-driven initiator that owns the write port and both read ports of the team's 8x8 register file.
- Accepts one operation at a time over a valid/ready command handshake.
- For each operation it reads two source registers, computes an 8-bit ALU result and writes it back to a destination register.
- It then returns the result and flags over a valid/ready response handshake.
- Sits between the control unit and the register file.

Parameters:
- ADDRESS_WIDTH, 3: register address width; the file has 2**ADDRESS_WIDTH registers.
- BUS_WIDTH, 8: data width of registers, immediate and result.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer can accept a command.
- cmd_op  input  3  opcode.
- cmd_rd  input  ADDRESS_WIDTH  destination register.
- cmd_rs1  input  ADDRESS_WIDTH  source A.
- cmd_rs2  input  ADDRESS_WIDTH  source B.
- cmd_imm  input  BUS_WIDTH  immediate for LDI.
- addrA  output  ADDRESS_WIDTH  to register file read port A.
- addrB  output  ADDRESS_WIDTH  to register file read port B.
- Data_A  input  BUS_WIDTH  combinational read data A from register file.
- Data_B  input  BUS_WIDTH  combinational read data B from register file.
- write_addr  output  ADDRESS_WIDTH  register file write address.
- data_in  output  BUS_WIDTH  register file write data.
- write_enable  output  1  register file write strobe.
- resp_valid  output  1  result available.
- resp_ready  input  1  consumer takes result.
- resp_data  output  BUS_WIDTH  computed result.
- resp_zero  output  1  result == 0.
- resp_carry  output  1  carry out (ADD) or borrow (SUB); 0 for other ops.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Values during reset: state=IDLE, cmd_ready=1, write_enable=0, resp_valid=0. All datapath registers are 0, so addrA=addrB=write_addr=0, data_in=0, resp_data=0, resp_zero=0, resp_carry=0.
- Reset mid-operation aborts the operation immediately. write_enable drops asynchronously, so a partial write is never issued after reset asserts.
- FSM states, one cycle each unless noted:
  - IDLE: cmd_ready=1. If cmd_valid, latch op, rd, rs1, rs2 and imm, then go to READ.
  - READ: addrA=rs1, addrB=rs2 (registered outputs, updated on the IDLE->READ edge). At the end of the cycle capture Data_A and Data_B into operand registers, then go to EXEC.
  - EXEC: compute the BUS_WIDTH+1 bit result into the result register. If op is NOP go to RESP, otherwise go to WRITE.
  - WRITE: write_enable=1 for exactly one cycle, with write_addr=rd and data_in=result. Then go to RESP.
  - RESP: resp_valid=1, with resp_data, resp_zero and resp_carry stable. When resp_ready, go to IDLE.
- cmd_ready is 1 only in IDLE.
- Opcodes (A = operand A, B = operand B):
  - 000 ADD: A+B, carry = bit BUS_WIDTH of the sum.
  - 001 SUB: A-B, mod 2**BUS_WIDTH; carry = borrow = (A<B).
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 MOV: A.
  - 110 LDI: imm; sources are still read but ignored.
  - 111 NOP: result = A, no writeback.
- Arithmetic wraps mod 2**BUS_WIDTH.
- Latency:
  - Command accept to write_enable: 3 edges.
  - Command accept to resp_valid: 4 edges for a writing op, 3 for NOP.
  - Minimum throughput is one command per 5 cycles.
- rd may equal rs1 or rs2. Operands are captured in READ, before the write in WRITE, so the old value is used.
- Back-to-back commands: the next command's READ follows the previous command's WRITE, so it sees the updated value (no hazard).
- resp_valid holds, with the response fields stable, until resp_ready, even for many cycles. No new command is accepted meanwhile.
- cmd fields are don't-care outside the IDLE handshake cycle.

Decomposition:
- Shared package regfile_pkg:
  - Opcode localparams OP_ADD..OP_NOP.
  - FSM state encoding (IDLE, READ, EXEC, WRITE, RESP).
  - Default widths.
- One natural sub-module, seq_alu: purely combinational.
  - Inputs: op, A, B, imm.
  - Outputs: result[BUS_WIDTH-1:0], carry, zero.
- The FSM and handshakes stay in the top.

Test Plan:
- Reset, then LDI rd=3 imm=0x5A -> write_enable high on edge 3 with write_addr=3 and data_in=0x5A; resp_valid with resp_data=0x5A, zero=0, carry=0.
- Preload r1=0xF0 and r2=0x20 via LDI, then ADD rd=4 rs1=1 rs2=2 -> addrA=1, addrB=2 in READ; data_in=0x10, carry=1; resp_data=0x10.
- SUB rd=5 rs1=2 rs2=1 (0x20-0xF0) -> resp_data=0x30, carry(borrow)=1. Then SUB rd=6 rs1=1 rs2=1 -> resp_data=0x00, zero=1, carry=0.
- NOP rs1=1 -> write_enable never asserts; resp_valid after 3 edges with resp_data=0xF0. cmd_valid held high during RESP with resp_ready=0 for 10 cycles -> cmd_ready=0, resp fields stable.
- In-place op: r1=0xF0, ADD rd=1 rs1=1 rs2=1 -> data_in=0xE0, carry=1. Next MOV rd=7 rs1=1 -> resp_data=0xE0.
- Assert rst asynchronously while in WRITE -> write_enable falls before the next clk edge, and all outputs return to reset values. A command after release executes normally.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file operation sequencer:
// default widths, opcode values and the sequencer FSM state type.
package regfile_pkg;

  localparam int unsigned ADDRESS_WIDTH_DEF = 3;
  localparam int unsigned BUS_WIDTH_DEF     = 8;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_MOV = 3'b101;
  localparam logic [2:0] OP_LDI = 3'b110;
  localparam logic [2:0] OP_NOP = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WRITE = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

endpackage

// File: rtl/seq_alu.sv
// Combinational ALU for the sequencer: one result per opcode, plus a
// carry/borrow flag (ADD/SUB only) and a zero flag on the result.
module seq_alu
  import regfile_pkg::*;
#(
  parameter int unsigned BUS_WIDTH = BUS_WIDTH_DEF
) (
  input  logic [2:0]           i_op,
  input  logic [BUS_WIDTH-1:0] i_a,
  input  logic [BUS_WIDTH-1:0] i_b,
  input  logic [BUS_WIDTH-1:0] i_imm,
  output logic [BUS_WIDTH-1:0] o_result,
  output logic                 o_carry,
  output logic                 o_zero
);

  logic [BUS_WIDTH:0] w_sum;
  logic [BUS_WIDTH:0] w_diff;

  // Extended-width add/subtract: the top bit is carry for ADD and borrow (A<B) for SUB.
  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff = {1'b0, i_a} - {1'b0, i_b};

  // Opcode decode and flag generation
  always_comb begin
    o_carry  = 1'b0;
    o_result = i_a;
    case (i_op)
      OP_ADD:  {o_carry, o_result} = w_sum;
      OP_SUB:  {o_carry, o_result} = w_diff;
      OP_AND:  o_result = i_a & i_b;
      OP_OR:   o_result = i_a | i_b;
      OP_XOR:  o_result = i_a ^ i_b;
      OP_MOV:  o_result = i_a;
      OP_LDI:  o_result = i_imm;
      default: o_result = i_a;
    endcase
    o_zero = (o_result == '0);
  end

endmodule

// File: rtl/regfile_op_sequencer.sv
// Command-driven sequencer owning the register file's read and write ports.
// Each command: read two sources, compute an ALU result, write it back
// (except NOP), then present the result on a valid/ready response channel.
module regfile_op_sequencer
  import regfile_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = ADDRESS_WIDTH_DEF,
  parameter int unsigned BUS_WIDTH     = BUS_WIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [2:0]               cmd_op,
  input  logic [ADDRESS_WIDTH-1:0] cmd_rd,
  input  logic [ADDRESS_WIDTH-1:0] cmd_rs1,
  input  logic [ADDRESS_WIDTH-1:0] cmd_rs2,
  input  logic [BUS_WIDTH-1:0]     cmd_imm,
  output logic [ADDRESS_WIDTH-1:0] addrA,
  output logic [ADDRESS_WIDTH-1:0] addrB,
  input  logic [BUS_WIDTH-1:0]     Data_A,
  input  logic [BUS_WIDTH-1:0]     Data_B,
  output logic [ADDRESS_WIDTH-1:0] write_addr,
  output logic [BUS_WIDTH-1:0]     data_in,
  output logic                     write_enable,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [BUS_WIDTH-1:0]     resp_data,
  output logic                     resp_zero,
  output logic                     resp_carry
);

  state_e                   r_state;
  state_e                   w_next;

  logic [2:0]               r_op;
  logic [ADDRESS_WIDTH-1:0] r_rd;
  logic [ADDRESS_WIDTH-1:0] r_addr_a;
  logic [ADDRESS_WIDTH-1:0] r_addr_b;
  logic [BUS_WIDTH-1:0]     r_imm;
  logic [BUS_WIDTH-1:0]     r_opa;
  logic [BUS_WIDTH-1:0]     r_opb;
  logic [BUS_WIDTH:0]       r_result;
  logic                     r_zero;

  logic [BUS_WIDTH-1:0]     w_alu_result;
  logic                     w_alu_carry;
  logic                     w_alu_zero;

  seq_alu #(
    .BUS_WIDTH (BUS_WIDTH)
  ) u_alu (
    .i_op     (r_op),
    .i_a      (r_opa),
    .i_b      (r_opb),
    .i_imm    (r_imm),
    .o_result (w_alu_result),
    .o_carry  (w_alu_carry),
    .o_zero   (w_alu_zero)
  );

  // FSM state register; async reset clears it so write_enable drops at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic: fixed walk through READ/EXEC, WRITE skipped for NOP
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (cmd_valid) w_next = ST_READ;
      ST_READ:  w_next = ST_EXEC;
      ST_EXEC:  w_next = (r_op == OP_NOP) ? ST_RESP : ST_WRITE;
      ST_WRITE: w_next = ST_RESP;
      ST_RESP:  if (resp_ready) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // State-decoded handshake and write strobe outputs
  always_comb begin
    cmd_ready    = 1'b0;
    write_enable = 1'b0;
    resp_valid   = 1'b0;
    case (r_state)
      ST_IDLE:  cmd_ready    = 1'b1;
      ST_WRITE: write_enable = 1'b1;
      ST_RESP:  resp_valid   = 1'b1;
      default:  ;
    endcase
  end

  // Datapath: latch command, capture operands, register ALU result and flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op     <= '0;
      r_rd     <= '0;
      r_addr_a <= '0;
      r_addr_b <= '0;
      r_imm    <= '0;
      r_opa    <= '0;
      r_opb    <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_op     <= cmd_op;
            r_rd     <= cmd_rd;
            r_addr_a <= cmd_rs1;
            r_addr_b <= cmd_rs2;
            r_imm    <= cmd_imm;
          end
        end
        ST_READ: begin
          r_opa <= Data_A;
          r_opb <= Data_B;
        end
        ST_EXEC: begin
          r_result <= {w_alu_carry, w_alu_result};
          r_zero   <= w_alu_zero;
        end
        default: ;
      endcase
    end
  end

  assign addrA      = r_addr_a;
  assign addrB      = r_addr_b;
  assign write_addr = r_rd;
  assign data_in    = r_result[BUS_WIDTH-1:0];
  assign resp_data  = r_result[BUS_WIDTH-1:0];
  assign resp_carry = r_result[BUS_WIDTH];
  assign resp_zero  = r_zero;

endmodule

// File: tb/tb_regfile_op_sequencer.sv
// Directed bench for regfile_op_sequencer with a behavioural register file,
// a shadow register model and a response scoreboard.
module tb_regfile_op_sequencer;

  localparam logic [2:0] ADD = 3'b000;
  localparam logic [2:0] SUB = 3'b001;
  localparam logic [2:0] AND = 3'b010;
  localparam logic [2:0] OR  = 3'b011;
  localparam logic [2:0] XOR = 3'b100;
  localparam logic [2:0] MOV = 3'b101;
  localparam logic [2:0] LDI = 3'b110;
  localparam logic [2:0] NOP = 3'b111;

  typedef struct {
    logic [7:0] data;
    logic       zero;
    logic       carry;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [2:0] cmd_rd;
  logic [2:0] cmd_rs1;
  logic [2:0] cmd_rs2;
  logic [7:0] cmd_imm;
  logic [2:0] addrA;
  logic [2:0] addrB;
  logic [7:0] Data_A;
  logic [7:0] Data_B;
  logic [2:0] write_addr;
  logic [7:0] data_in;
  logic       write_enable;
  logic       resp_valid;
  logic       resp_ready;
  logic [7:0] resp_data;
  logic       resp_zero;
  logic       resp_carry;

  int errors = 0;
  int checks = 0;

  exp_t sb[$];
  logic [7:0] rf     [8] = '{default: 8'h00};
  logic [7:0] exp_rf [8] = '{default: 8'h00};

  regfile_op_sequencer #(
    .ADDRESS_WIDTH (3),
    .BUS_WIDTH     (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_rd       (cmd_rd),
    .cmd_rs1      (cmd_rs1),
    .cmd_rs2      (cmd_rs2),
    .cmd_imm      (cmd_imm),
    .addrA        (addrA),
    .addrB        (addrB),
    .Data_A       (Data_A),
    .Data_B       (Data_B),
    .write_addr   (write_addr),
    .data_in      (data_in),
    .write_enable (write_enable),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_data    (resp_data),
    .resp_zero    (resp_zero),
    .resp_carry   (resp_carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural register file: combinational reads, clocked write
  assign Data_A = rf[addrA];
  assign Data_B = rf[addrB];
  always @(posedge clk) if (write_enable) rf[write_addr] <= data_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_cmd_ready"},  cmd_ready,    1);
    chk({pfx, "_we"},         write_enable, 0);
    chk({pfx, "_resp_valid"}, resp_valid,   0);
    chk({pfx, "_addrA"},      addrA,        0);
    chk({pfx, "_addrB"},      addrB,        0);
    chk({pfx, "_write_addr"}, write_addr,   0);
    chk({pfx, "_data_in"},    data_in,      0);
    chk({pfx, "_resp_data"},  resp_data,    0);
    chk({pfx, "_resp_zero"},  resp_zero,    0);
    chk({pfx, "_resp_carry"}, resp_carry,   0);
  endtask

  task automatic wait_ready();
    int unsigned n = 0;
    while (cmd_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_ready_wait", cmd_ready, 1);
  endtask

  task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                       input logic [2:0] rs2, input logic [7:0] imm);
    wait_ready();
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_rd    = rd;
    cmd_rs1   = rs1;
    cmd_rs2   = rs2;
    cmd_imm   = imm;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = 3'($urandom);
    cmd_rd    = 3'($urandom);
    cmd_rs1   = 3'($urandom);
    cmd_rs2   = 3'($urandom);
    cmd_imm   = 8'($urandom);
  endtask

  // Full command: timing checks per cycle, optional response stall, scoreboard pop
  task automatic do_op(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                       input logic [2:0] rs2, input logic [7:0] imm,
                       input int unsigned hold, input bit valid_in_hold);
    exp_t e;
    exp_t got;
    logic [7:0] a;
    logic [7:0] b;
    logic [8:0] t;
    a = exp_rf[rs1];
    b = exp_rf[rs2];
    e.carry = 1'b0;
    case (op)
      ADD: begin t = {1'b0, a} + {1'b0, b}; e.data = t[7:0]; e.carry = t[8]; end
      SUB: begin e.data = a - b; e.carry = (a < b); end
      AND: e.data = a & b;
      OR:  e.data = a | b;
      XOR: e.data = a ^ b;
      LDI: e.data = imm;
      default: e.data = a;
    endcase
    e.zero = (e.data == 8'h00);
    sb.push_back(e);

    issue(op, rd, rs1, rs2, imm);
    @(negedge clk);
    chk("read_addrA", addrA, rs1);
    chk("read_addrB", addrB, rs2);
    chk("read_we", write_enable, 0);
    chk("read_cmd_ready", cmd_ready, 0);
    chk("read_resp_valid", resp_valid, 0);
    @(negedge clk);
    chk("exec_we", write_enable, 0);
    @(negedge clk);
    if (op != NOP) begin
      chk("write_we", write_enable, 1);
      chk("write_addr", write_addr, rd);
      chk("write_data", data_in, e.data);
      chk("write_resp_valid", resp_valid, 0);
      @(posedge clk);
      exp_rf[rd] = e.data;
      @(negedge clk);
    end
    chk("resp_we", write_enable, 0);
    chk("resp_valid", resp_valid, 1);

    for (int unsigned i = 0; i < hold; i++) begin
      if (valid_in_hold) begin
        cmd_valid = 1'b1;
        cmd_op    = LDI;
        cmd_rd    = 3'($urandom);
        cmd_imm   = 8'($urandom);
      end
      @(negedge clk);
      chk("hold_resp_valid", resp_valid, 1);
      chk("hold_cmd_ready", cmd_ready, 0);
      chk("hold_we", write_enable, 0);
      chk("hold_resp_data", resp_data, e.data);
      chk("hold_resp_zero", resp_zero, e.zero);
      chk("hold_resp_carry", resp_carry, e.carry);
    end
    cmd_valid  = 1'b0;
    resp_ready = 1'b1;

    chk("sb_nonempty", (sb.size() > 0), 1);
    if (sb.size() > 0) begin
      got = sb.pop_front();
      chk("resp_data", resp_data, got.data);
      chk("resp_zero", resp_zero, got.zero);
      chk("resp_carry", resp_carry, got.carry);
    end
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    @(negedge clk);
    chk("post_resp_valid", resp_valid, 0);
    chk("post_cmd_ready", cmd_ready, 1);
  endtask

  initial begin
    rst        = 1'b1;
    cmd_valid  = 1'b0;
    cmd_op     = '0;
    cmd_rd     = '0;
    cmd_rs1    = '0;
    cmd_rs2    = '0;
    cmd_imm    = '0;
    resp_ready = 1'b0;

    #12;
    chk_reset_outputs("rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    do_op(LDI, 3'd3, 3'd0, 3'd0, 8'h5A, 0, 0);
    do_op(LDI, 3'd1, 3'd2, 3'd4, 8'hF0, 0, 0);
    do_op(LDI, 3'd2, 3'd0, 3'd0, 8'h20, 2, 0);
    do_op(ADD, 3'd4, 3'd1, 3'd2, 8'h00, 0, 0);
    do_op(SUB, 3'd5, 3'd2, 3'd1, 8'h00, 0, 0);
    do_op(SUB, 3'd6, 3'd1, 3'd1, 8'h00, 0, 0);
    do_op(NOP, 3'd7, 3'd1, 3'd0, 8'h00, 10, 1);
    do_op(ADD, 3'd1, 3'd1, 3'd1, 8'h00, 0, 0);
    do_op(MOV, 3'd7, 3'd1, 3'd5, 8'h00, 0, 0);
    do_op(AND, 3'd0, 3'd1, 3'd3, 8'h00, 0, 0);
    do_op(OR,  3'd0, 3'd1, 3'd3, 8'h00, 0, 0);
    do_op(XOR, 3'd0, 3'd1, 3'd3, 8'h00, 1, 0);
    do_op(ADD, 3'd0, 3'd1, 3'd2, 8'h00, 0, 0);
    do_op(LDI, 3'd5, 3'd0, 3'd0, 8'h00, 0, 0);

    // Abort a LDI while its write strobe is high
    issue(LDI, 3'd6, 3'd0, 3'd0, 8'h99);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("abort_we_before", write_enable, 1);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outputs("abort");
    @(negedge clk);
    @(negedge clk);
    chk_reset_outputs("abort_hold");
    rst = 1'b0;
    @(negedge clk);

    do_op(LDI, 3'd5, 3'd0, 3'd0, 8'h33, 0, 0);
    do_op(MOV, 3'd6, 3'd5, 3'd0, 8'h00, 0, 0);

    @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    for (int i = 0; i < 8; i++) chk($sformatf("rf%0d", i), rf[i], exp_rf[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time bound so the bench always terminates
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
